// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM states, protection bit positions and
// the address-region to PPROT permission mapping.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_t;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

    localparam int REGION_PRIV_BIT   = 8;
    localparam int REGION_NONSEC_BIT = 9;
    localparam int REGION_INSTR_BIT  = 10;
    localparam int REGION_LSB        = REGION_PRIV_BIT;
    localparam int REGION_MSB        = REGION_INSTR_BIT;

    localparam int WAIT_CNT_WIDTH = 4;

    // PPROT bits that must be set to reach the region selected by paddr[10:8].
    function automatic logic [2:0] getPprot(input logic [2:0] region);
        logic [2:0] req;
        req = '0;
        req[PPROT_PRIV]   = region[REGION_PRIV_BIT - REGION_LSB];
        req[PPROT_NONSEC] = region[REGION_NONSEC_BIT - REGION_LSB];
        req[PPROT_INSTR]  = region[REGION_INSTR_BIT - REGION_LSB];
        return req;
    endfunction

    function automatic logic [2:0] getAddrforPprot(input logic [2:0] prot);
        logic [2:0] region;
        region = '0;
        region[REGION_PRIV_BIT - REGION_LSB]   = prot[PPROT_PRIV];
        region[REGION_NONSEC_BIT - REGION_LSB] = prot[PPROT_NONSEC];
        region[REGION_INSTR_BIT - REGION_LSB]  = prot[PPROT_INSTR];
        return region;
    endfunction

endpackage

// File: rtl/apb_reg_completer_if.sv
// APB4 completer-side bus bundle with requester (master) and completer (slave) views.
interface apb_reg_completer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [2:0]            pprot;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_regfile.sv
// Register storage behind the APB completer: byte-strobed synchronous write,
// asynchronous read, synchronous clear.
module apb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]  index,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) begin
                    mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/apb_reg_completer.sv
// APB4 register completer: latches the setup phase, inserts WAIT_STATES access
// cycles, then completes with a one-cycle PREADY carrying decode/protection errors.
module apb_reg_completer
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    apb_reg_completer_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = $clog2(NUM_REGS);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);

    apb_state_t state, state_next;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt, wait_cnt_next;
    logic latch_en;
    logic proto_err, proto_err_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            prot_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;

    logic [REGION_LSB-3:0] word;
    logic                  align_err, range_err, prot_err, xfer_err;
    logic                  done, wr_en;
    logic [DATA_WIDTH-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            proto_err <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            prot_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            proto_err <= proto_err_next;
            if (latch_en) begin
                addr_q  <= bus.paddr;
                write_q <= bus.pwrite;
                prot_q  <= bus.pprot;
                wdata_q <= bus.pwdata;
                strb_q  <= bus.pstrb;
            end
        end
    end

    // With zero wait states the first access cycle must already complete, so setup jumps to DONE.
    always_comb begin
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        proto_err_next = proto_err;
        latch_en       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    latch_en       = 1'b1;
                    proto_err_next = 1'b0;
                    wait_cnt_next  = WAIT_LOAD;
                    state_next     = (WAIT_STATES == 0) ? DONE : WAIT;
                end else if (bus.psel && bus.penable) begin
                    proto_err_next = 1'b1;
                    state_next     = DONE;
                end
            end
            WAIT: begin
                if (!bus.psel) begin
                    proto_err_next = 1'b1;
                    wait_cnt_next  = '0;
                    state_next     = DONE;
                end else if (bus.penable) begin
                    wait_cnt_next = wait_cnt - 1'b1;
                    if (wait_cnt <= 1) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Region bits [10:8] only gate permission; the word offset below them picks the register.
    assign word      = addr_q[REGION_LSB-1:2];
    assign align_err = (addr_q[1:0] != 2'b00);
    assign range_err = (|addr_q[ADDR_WIDTH-1:REGION_MSB+1]) || (32'(word) >= 32'(NUM_REGS));
    assign prot_err  = |(getPprot(addr_q[REGION_MSB:REGION_LSB]) & ~prot_q);
    assign xfer_err  = proto_err || align_err || range_err || prot_err;

    assign done  = (state == DONE);
    assign wr_en = done && write_q && !xfer_err;

    apb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_en),
        .index (word[IDX_WIDTH-1:0]),
        .wstrb (strb_q),
        .wdata (wdata_q),
        .rdata (rd_data)
    );

    assign bus.pready  = done;
    assign bus.pslverr = done && xfer_err;
    assign bus.prdata  = (done && !write_q && !xfer_err) ? rd_data : '0;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench for apb_reg_completer: three instances (1, 0 and 3 wait states)
// share clock, reset and bus stimulus, with per-instance select.
module tb_apb_reg_completer;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [2:0]  psel_v  = '0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] paddr   = '0;
    logic [2:0]  pprot   = '0;
    logic [31:0] pwdata  = '0;
    logic [3:0]  pstrb   = '0;

    logic [2:0]       pready_v;
    logic [2:0]       pslverr_v;
    logic [2:0][31:0] prdata_v;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance 0: 1 wait state, instance 1: 0 wait states, instance 2: 3 wait states.
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        apb_reg_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

        assign bus.psel    = psel_v[g];
        assign bus.penable = penable;
        assign bus.pwrite  = pwrite;
        assign bus.paddr   = paddr;
        assign bus.pprot   = pprot;
        assign bus.pwdata  = pwdata;
        assign bus.pstrb   = pstrb;
        assign pready_v[g]  = bus.pready;
        assign pslverr_v[g] = bus.pslverr;
        assign prdata_v[g]  = bus.prdata;

        apb_reg_completer #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .NUM_REGS    (64),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        psel_v  = '0;
        penable = 1'b0;
    endtask

    // One transfer; returns after the PREADY cycle is sampled, leaving the bus driven so a
    // following call issues its setup in the cycle straight after DONE.
    task automatic apply_stimulus(input int d, input logic wr, input logic [31:0] addr,
                                  input logic [2:0] prot, input logic [31:0] wdata,
                                  input logic [3:0] strb, output int lat,
                                  output logic err, output logic [31:0] rdata);
        logic got;
        @(posedge clk); #1;
        psel_v    = '0;
        psel_v[d] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pprot     = prot;
        pwdata    = wdata;
        pstrb     = strb;
        @(negedge clk);
        check_output("setup_pready", 32'(pready_v[d]), 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        lat   = 0;
        got   = 1'b0;
        err   = 1'b0;
        rdata = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (pready_v[d]) begin
                got   = 1'b1;
                err   = pslverr_v[d];
                rdata = prdata_v[d];
            end else begin
                lat++;
                @(posedge clk); #1;
                pwdata = ~wdata;
                paddr  = addr ^ 32'h10;
            end
        end
    endtask

    task automatic run_xfer(input string tag, input int d, input logic wr, input logic [31:0] addr,
                            input logic [2:0] prot, input logic [31:0] wdata, input logic [3:0] strb,
                            input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
        int          lat;
        logic        err;
        logic [31:0] rdata;
        apply_stimulus(d, wr, addr, prot, wdata, strb, lat, err, rdata);
        check_output({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_output({tag, "_err"}, 32'(err), 32'(exp_err));
        if (!wr) begin
            check_output({tag, "_rdata"}, rdata, exp_rdata);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_pready",  32'(pready_v[0]),  32'd0);
        check_output("rst_pslverr", 32'(pslverr_v[0]), 32'd0);
        check_output("rst_prdata",  prdata_v[0],       32'd0);
        check_output("rst_pready_ws0", 32'(pready_v[1]), 32'd0);
        check_output("rst_pready_ws3", 32'(pready_v[2]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic write/read with one wait state.
        run_xfer("wr004", 0, 1'b1, 32'h004, 3'b000, 32'hFFFF_FFFF, 4'hF, 1, 1'b0, 32'h0);
        run_xfer("rd004", 0, 1'b0, 32'h004, 3'b000, 32'h0, 4'h0, 1, 1'b0, 32'hFFFF_FFFF);

        // Register 33 reached through the unprotected and fully protected aliases.
        run_xfer("wr084", 0, 1'b1, 32'h084, 3'b000, 32'h1234_5678, 4'hF, 1, 1'b0, 32'h0);
        run_xfer("rd784_p7", 0, 1'b0, 32'h784, 3'b111, 32'h0, 4'h0, 1, 1'b0, 32'h1234_5678);
        run_xfer("rd784_p6", 0, 1'b0, 32'h784, 3'b110, 32'h0, 4'h0, 1, 1'b1, 32'h0);
        run_xfer("rd784_p5", 0, 1'b0, 32'h784, 3'b101, 32'h0, 4'h0, 1, 1'b1, 32'h0);
        run_xfer("rd784_p3", 0, 1'b0, 32'h784, 3'b011, 32'h0, 4'h0, 1, 1'b1, 32'h0);

        // Byte strobes, no-op write, aliased write and a denied write.
        run_xfer("wr084_s1", 0, 1'b1, 32'h084, 3'b000, 32'hFFFF_FFFF, 4'h1, 1, 1'b0, 32'h0);
        run_xfer("rd084_a",  0, 1'b0, 32'h084, 3'b000, 32'h0, 4'h0, 1, 1'b0, 32'h1234_56FF);
        run_xfer("wr084_s0", 0, 1'b1, 32'h084, 3'b000, 32'h0000_0000, 4'h0, 1, 1'b0, 32'h0);
        run_xfer("rd084_b",  0, 1'b0, 32'h084, 3'b000, 32'h0, 4'h0, 1, 1'b0, 32'h1234_56FF);
        run_xfer("wr384_s8", 0, 1'b1, 32'h384, 3'b011, 32'hAB00_0000, 4'h8, 1, 1'b0, 32'h0);
        run_xfer("rd084_c",  0, 1'b0, 32'h084, 3'b000, 32'h0, 4'h0, 1, 1'b0, 32'hAB34_56FF);
        run_xfer("wr484_den", 0, 1'b1, 32'h484, 3'b011, 32'h0000_0000, 4'hF, 1, 1'b1, 32'h0);
        run_xfer("rd084_d",  0, 1'b0, 32'h084, 3'b000, 32'h0, 4'h0, 1, 1'b0, 32'hAB34_56FF);

        // Decode errors: out of range and misaligned.
        run_xfer("rd800", 0, 1'b0, 32'h800, 3'b000, 32'h0, 4'h0, 1, 1'b1, 32'h0);
        run_xfer("rd003", 0, 1'b0, 32'h003, 3'b000, 32'h0, 4'h0, 1, 1'b1, 32'h0);
        run_xfer("wr008", 0, 1'b1, 32'h008, 3'b000, 32'h1111_2222, 4'hF, 1, 1'b0, 32'h0);

        // psel dropped in the first access cycle of a write.
        idle_cycle();
        @(posedge clk); #1;
        psel_v = 3'b001; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h008; pprot = 3'b000; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        @(posedge clk); #1;
        psel_v = 3'b000; penable = 1'b1;
        @(negedge clk);
        check_output("drop_pready_c1", 32'(pready_v[0]), 32'd0);
        @(posedge clk); #1;
        penable = 1'b0;
        @(negedge clk);
        check_output("drop_pready",  32'(pready_v[0]),  32'd1);
        check_output("drop_pslverr", 32'(pslverr_v[0]), 32'd1);
        check_output("drop_prdata",  prdata_v[0],       32'd0);
        @(negedge clk);
        check_output("drop_pulse", 32'(pready_v[0]), 32'd0);
        run_xfer("rd008_a", 0, 1'b0, 32'h008, 3'b000, 32'h0, 4'h0, 1, 1'b0, 32'h1111_2222);

        // Access phase without a preceding setup.
        idle_cycle();
        @(posedge clk); #1;
        psel_v = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = 32'h004; pprot = 3'b000;
        @(negedge clk);
        check_output("nosetup_idle", 32'(pready_v[0]), 32'd0);
        @(posedge clk); #1;
        psel_v = 3'b000; penable = 1'b0;
        @(negedge clk);
        check_output("nosetup_pready",  32'(pready_v[0]),  32'd1);
        check_output("nosetup_pslverr", 32'(pslverr_v[0]), 32'd1);
        check_output("nosetup_prdata",  prdata_v[0],       32'd0);

        // Zero wait states, back-to-back.
        run_xfer("ws0_wr010", 1, 1'b1, 32'h010, 3'b000, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 32'h0);
        run_xfer("ws0_rd010", 1, 1'b0, 32'h010, 3'b000, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D);
        run_xfer("ws0_rd014", 1, 1'b0, 32'h014, 3'b000, 32'h0, 4'h0, 0, 1'b0, 32'h0);

        // Three wait states, back-to-back.
        run_xfer("ws3_wr010", 2, 1'b1, 32'h010, 3'b000, 32'h0BAD_BEEF, 4'hF, 3, 1'b0, 32'h0);
        run_xfer("ws3_rd010", 2, 1'b0, 32'h010, 3'b000, 32'h0, 4'h0, 3, 1'b0, 32'h0BAD_BEEF);
        run_xfer("ws3_rd310", 2, 1'b0, 32'h310, 3'b011, 32'h0, 4'h0, 3, 1'b0, 32'h0BAD_BEEF);

        // Reset during the wait state of a write.
        idle_cycle();
        @(posedge clk); #1;
        psel_v = 3'b001; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h008; pprot = 3'b000; pwdata = 32'hA5A5_A5A5; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        check_output("rstw_pready_wait", 32'(pready_v[0]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; psel_v = 3'b000; penable = 1'b0;
        @(negedge clk);
        check_output("rstw_pready_a", 32'(pready_v[0]), 32'd0);
        @(negedge clk);
        check_output("rstw_pready_b", 32'(pready_v[0]), 32'd0);
        run_xfer("rstw_rd008", 0, 1'b0, 32'h008, 3'b000, 32'h0, 4'h0, 1, 1'b0, 32'h0);
        run_xfer("rstw_rd004", 0, 1'b0, 32'h004, 3'b000, 32'h0, 4'h0, 1, 1'b0, 32'h0);
        run_xfer("rstw_ws3_rd010", 2, 1'b0, 32'h010, 3'b000, 32'h0, 4'h0, 3, 1'b0, 32'h0);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_reg_completer.md
APB_REG_COMPLETER -- requirements
Module: apb_reg_completer

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, PADDR width.
REQ-002 Parameter DATA_WIDTH, default 32, PWDATA/PRDATA width; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 Parameter NUM_REGS, default 64, register-file depth (power of 2).
REQ-004 Parameter WAIT_STATES, default 1, access-phase wait cycles inserted before PREADY (0..15).
REQ-005 clk  in  1  rising-edge clock (APB PCLK).
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 psel  in  1  completer select.
REQ-008 penable  in  1  access-phase indicator.
REQ-009 pwrite  in  1  1=write, 0=read.
REQ-010 paddr  in  ADDR_WIDTH  byte address.
REQ-011 pprot  in  3  protection: [0] privileged, [1] non-secure, [2] instruction.
REQ-012 pwdata  in  DATA_WIDTH  write data.
REQ-013 pstrb  in  STRB_WIDTH  write byte-lane strobes.
REQ-014 pready  out  1  transfer completion, registered.
REQ-015 prdata  out  DATA_WIDTH  read data, valid only while pready=1.
REQ-016 pslverr  out  1  transfer error, valid only while pready=1.

Function
REQ-017 FSM states IDLE, WAIT, DONE; IDLE on reset.
REQ-018 IDLE: psel=1 & penable=0 (setup) -> latch paddr/pwrite/pprot/pwdata/pstrb, load wait counter with WAIT_STATES, go WAIT; psel=1 & penable=1 with no prior setup -> DONE with error flag set.
REQ-019 WAIT: counter decrements each cycle penable=1; at 0 go DONE; first access cycle is the cycle after setup, so pready rises exactly WAIT_STATES cycles after first penable=1 cycle.
REQ-020 WAIT: psel=0 observed -> go DONE with error flag set (protocol error), counter abandoned.
REQ-021 DONE: pready=1 for exactly one cycle, then IDLE; back-to-back setup in the cycle after DONE accepted.
REQ-022 Latched values used for decode/commit; paddr/pwdata changes during WAIT ignored.
REQ-023 Errors (any -> pslverr=1): paddr[1:0]!=0; paddr[ADDR_WIDTH-1:11]!=0 or index>=NUM_REGS; protection violation; protocol error (REQ-018/020).
REQ-024 Register index = paddr[log2(NUM_REGS)+1:2].
REQ-025 Protection: paddr[8]=1 requires pprot[0]=1; paddr[9]=1 requires pprot[1]=1; paddr[10]=1 requires pprot[2]=1; any required bit 0 -> error.
REQ-026 Write commits at the DONE edge only if no error; byte lane i updated iff pstrb[i]=1; pstrb=0 is a legal no-op write.
REQ-027 Read: prdata = register contents in DONE; prdata=0 on error or when pready=0.
REQ-028 pready and pslverr are 0 in every cycle other than DONE.
REQ-029 Protection region bits [10:8] alias the same storage; address bits select permission only.

Reset
REQ-030 Reset asserted at any clock edge -> IDLE, pready=0, pslverr=0, prdata=0, counter=0, all registers 0, in-flight transfer dropped without commit.
REQ-031 Reset takes priority over all transfer activity; first setup accepted the cycle after reset deasserts.

Structure
REQ-032 apb_pkg holds the FSM state enum, protection bit positions/region bit constants, and getPprot/getAddrforPprot functions encoding REQ-025, shared with the bridge bench.
REQ-033 One sub-module apb_regfile: NUM_REGS x DATA_WIDTH storage, byte-strobed write port, asynchronous read port, synchronous reset.

Verification
REQ-034 WAIT_STATES=1: write 0xFFFFFFFF to 0x004, pprot=000, pstrb=F -> pready 1 cycle after first penable, pslverr=0; read 0x004 -> 0xFFFFFFFF.
REQ-035 Read 0x784 pprot=111 -> no error; pprot=110, 101, 011 each -> pslverr=1, prdata=0.
REQ-036 Sparse write: register 0x084 holds 0x12345678; write 0xFFFFFFFF pstrb=0x1 -> read returns 0x123456FF.
REQ-037 Read paddr=0x003 -> pslverr=1; psel dropped in first access cycle -> pready=1, pslverr=1 next cycle, no state change.
REQ-038 Reset asserted during WAIT of a write 0xA5A5A5A5 to 0x008 -> pready never asserted, subsequent read 0x008 -> 0x00000000.
REQ-039 WAIT_STATES=0 and 3: back-to-back reads -> pready exactly 0 / 3 cycles after penable, one-cycle pulse each.
